// File: rtl/ir_carrier_gen.sv
// ir_carrier_gen: multi-channel programmable IR carrier generator.
// Each channel runs a period/high counter. The period and high values are
// shadowed and are only picked up at a period boundary or at start.
// All outputs are registered: each flop takes the value that the next
// state/counter will produce, so the outputs are aligned with the counter.
// Optional build macro: IR_CARRIER_DRAIN_EN. When it is defined, dropping en
// lets the current period finish; when it is undefined, the channel stops at once.

module ir_carrier_ch #(
  parameter int W              = 16,
  parameter int DEFAULT_PERIOD = 1316,
  parameter int DEFAULT_HIGH   = 439
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_period,
  input  logic [W-1:0] cfg_high,
  input  logic         en,
  output logic         carrier_out,
  output logic         period_tick,
  output logic         busy
);

`ifdef IR_CARRIER_DRAIN_EN
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

  localparam logic [W-1:0] ONE   = W'(1);
  localparam logic [W-1:0] TWO   = W'(2);
  localparam logic [W-1:0] DEF_P = W'(DEFAULT_PERIOD);
  localparam logic [W-1:0] DEF_H = W'(DEFAULT_HIGH);

  state_t       state, nxt_state;
  logic [W-1:0] sh_per, sh_high, act_per, act_high, cnt;
  logic [W-1:0] nxt_per, nxt_high, nxt_cnt;
  logic [W-1:0] nxt_p_eff, nxt_h_eff;
  logic         wrap;

  // Periods below 2 cannot toggle, so they are clamped to 2.
  function automatic logic [W-1:0] eff_p(input logic [W-1:0] p);
    return (p < TWO) ? TWO : p;
  endfunction

  assign wrap = (cnt == eff_p(act_per) - ONE);

  // Shadow config: the last write wins until the next boundary consumes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_per  <= DEF_P;
      sh_high <= DEF_H;
    end else if (cfg_we) begin
      sh_per  <= cfg_period;
      sh_high <= cfg_high;
    end
  end

  // Next-state, counter and active-config selection.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_per   = act_per;
    nxt_high  = act_high;
    case (state)
      IDLE: begin
        if (en) begin
          nxt_state = RUN;
          nxt_cnt   = '0;
          nxt_per   = sh_per;
          nxt_high  = sh_high;
        end
      end
      RUN: begin
        if (!en) begin
`ifdef IR_CARRIER_DRAIN_EN
          // A stop on the final cycle of a period ends the period cleanly.
          if (wrap) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
          end else begin
            nxt_state = DRAIN;
            nxt_cnt   = cnt + ONE;
          end
`else
          nxt_state = IDLE;
          nxt_cnt   = '0;
`endif
        end else if (wrap) begin
          nxt_cnt  = '0;
          nxt_per  = sh_per;
          nxt_high = sh_high;
        end else begin
          nxt_cnt = cnt + ONE;
        end
      end
`ifdef IR_CARRIER_DRAIN_EN
      DRAIN: begin
        if (wrap) begin
          nxt_state = en ? RUN : IDLE;
          nxt_cnt   = '0;
          nxt_per   = sh_per;
          nxt_high  = sh_high;
        end else begin
          nxt_cnt = cnt + ONE;
          if (en) nxt_state = RUN;
        end
      end
`endif
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Effective period and high time of the upcoming cycle; used to register the outputs.
  always_comb begin
    nxt_p_eff = eff_p(nxt_per);
    nxt_h_eff = (nxt_high > nxt_p_eff) ? nxt_p_eff : nxt_high;
  end

  // State, counter, active config and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      act_per     <= DEF_P;
      act_high    <= DEF_H;
      carrier_out <= 1'b0;
      period_tick <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= nxt_state;
      cnt         <= nxt_cnt;
      act_per     <= nxt_per;
      act_high    <= nxt_high;
      carrier_out <= (nxt_state != IDLE) && (nxt_cnt < nxt_h_eff);
      period_tick <= (nxt_state != IDLE) && (nxt_cnt == nxt_p_eff - ONE);
      busy        <= (nxt_state != IDLE);
    end
  end

endmodule

module ir_carrier_gen #(
  parameter int CHANNELS       = 2,
  parameter int W              = 16,
  parameter int DEFAULT_PERIOD = 1316,
  parameter int DEFAULT_HIGH   = 439,
  parameter int CW             = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cfg_we,
  input  logic [CW-1:0]       cfg_ch,
  input  logic [W-1:0]        cfg_period,
  input  logic [W-1:0]        cfg_high,
  input  logic [CHANNELS-1:0] en,
  output logic [CHANNELS-1:0] carrier_out,
  output logic [CHANNELS-1:0] period_tick,
  output logic [CHANNELS-1:0] busy
);

  // One channel instance per lane. An out-of-range cfg_ch matches no lane.
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic ch_we;
    assign ch_we = cfg_we && (int'(cfg_ch) == i);

    ir_carrier_ch #(
      .W              (W),
      .DEFAULT_PERIOD (DEFAULT_PERIOD),
      .DEFAULT_HIGH   (DEFAULT_HIGH)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .cfg_we      (ch_we),
      .cfg_period  (cfg_period),
      .cfg_high    (cfg_high),
      .en          (en[i]),
      .carrier_out (carrier_out[i]),
      .period_tick (period_tick[i]),
      .busy        (busy[i])
    );
  end

endmodule

// File: tb/tb_ir_carrier_gen.sv
// Testbench for ir_carrier_gen (3 channels so that cfg_ch=3 is out of range).
// The expected output after each edge is queued when the stimulus is driven
// and compared at the following negedge.
module tb_ir_carrier_gen;
  localparam int CH = 3;
  localparam int W  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_ch = '0;
  logic [W-1:0]  cfg_period = '0, cfg_high = '0;
  logic [CH-1:0] en = '0;
  logic [CH-1:0] carrier_out, period_tick, busy;

  ir_carrier_gen #(.CHANNELS(CH), .W(W), .DEFAULT_PERIOD(1316), .DEFAULT_HIGH(439)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_period(cfg_period), .cfg_high(cfg_high), .en(en),
    .carrier_out(carrier_out), .period_tick(period_tick), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         rst;
    logic [2:0] en;
    bit         we;
    logic [1:0] ch;
    logic [15:0] per, high;
    logic [2:0] car, tick, bsy;
  } vec_t;

  typedef struct {
    logic [2:0] car, tick, bsy;
    int         id;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int id, input logic [2:0] act, input logic [2:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s id=%0d: got %b want %b", name, id, act, exp);
    end
  endtask

  task automatic add(input bit rst, input logic [2:0] e, input bit we, input logic [1:0] ch,
                     input logic [15:0] p, input logic [15:0] h,
                     input logic [2:0] car, input logic [2:0] tick, input logic [2:0] bsy);
    vec_t v;
    v.rst = rst; v.en = e; v.we = we; v.ch = ch; v.per = p; v.high = h;
    v.car = car; v.tick = tick; v.bsy = bsy;
    vecs.push_back(v);
  endtask

  // Channel-0-only shorthand; the other channels stay idle.
  task automatic a0(input bit e, input bit we, input logic [15:0] p, input logic [15:0] h,
                    input bit car, input bit tick, input bit bsy);
    add(1'b0, {2'b00, e}, we, 2'd0, p, h, {2'b00, car}, {2'b00, tick}, {2'b00, bsy});
  endtask

  task automatic step(input logic [2:0] e, input bit we, input logic [1:0] ch,
                      input logic [15:0] p, input logic [15:0] h,
                      input logic [2:0] car, input logic [2:0] tick, input logic [2:0] bsy, input int id);
    exp_t x;
    en = e; cfg_we = we; cfg_ch = ch; cfg_period = p; cfg_high = h;
    x.car = car; x.tick = tick; x.bsy = bsy; x.id = id;
    sb.push_back(x);
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard id=%0d: got empty queue want entry", id);
    end else begin
      x = sb.pop_front();
      check("carrier", x.id, carrier_out, x.car);
      check("tick",    x.id, period_tick, x.tick);
      check("busy",    x.id, busy,        x.bsy);
    end
  endtask

  // Asserts reset between clock edges and checks that the outputs clear without a clock.
  task automatic do_reset(input int id);
    @(negedge clk);
    #1;
    reset = 1'b0; en = '0; cfg_we = 1'b0;
    #1;
    check("rst_carrier", id, carrier_out, 3'b000);
    check("rst_tick",    id, period_tick, 3'b000);
    check("rst_busy",    id, busy,        3'b000);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Runtime update: P=6,H=2 then P=4,H=3 written at cnt=2.
    a0(0,1,6,2, 0,0,0);
    a0(1,0,0,0, 1,0,1);
    a0(1,0,0,0, 1,0,1);
    a0(1,0,0,0, 0,0,1);
    a0(1,1,4,3, 0,0,1);
    a0(1,0,0,0, 0,0,1);
    a0(1,0,0,0, 0,1,1);
    a0(1,0,0,0, 1,0,1);
    a0(1,0,0,0, 1,0,1);
    a0(1,0,0,0, 1,0,1);
    a0(1,0,0,0, 0,1,1);
    a0(1,1,6,2, 1,0,1);
    a0(1,0,0,0, 1,0,1);
    a0(1,0,0,0, 1,0,1);
    a0(1,0,0,0, 0,1,1);
    a0(1,0,0,0, 1,0,1);
    a0(1,0,0,0, 1,0,1);
    // Stop at cnt=1 of a P=6,H=2 period.
`ifdef IR_CARRIER_DRAIN_EN
    a0(0,0,0,0, 0,0,1);
    a0(0,0,0,0, 0,0,1);
    a0(0,0,0,0, 0,0,1);
    a0(0,0,0,0, 0,1,1);
    a0(0,0,0,0, 0,0,0);
    a0(0,0,0,0, 0,0,0);
    a0(1,0,0,0, 1,0,1);
    a0(1,0,0,0, 1,0,1);
    a0(0,0,0,0, 0,0,1);
    a0(0,0,0,0, 0,0,1);
    a0(1,0,0,0, 0,0,1);
    a0(1,0,0,0, 0,1,1);
    a0(1,0,0,0, 1,0,1);
    a0(1,0,0,0, 1,0,1);
`else
    a0(0,0,0,0, 0,0,0);
    a0(0,0,0,0, 0,0,0);
    a0(1,0,0,0, 1,0,1);
    a0(1,0,0,0, 1,0,1);
    a0(1,0,0,0, 0,0,1);
    a0(1,0,0,0, 0,0,1);
    a0(0,0,0,0, 0,0,0);
    a0(1,0,0,0, 1,0,1);
    a0(1,0,0,0, 1,0,1);
    a0(1,0,0,0, 0,0,1);
`endif
    // H=0, P=3: always low, tick every 3.
    add(1'b1, 3'b000, 1'b1, 2'd0, 16'd3, 16'd0, 3'b000, 3'b000, 3'b000);
    for (int k = 0; k < 6; k++) a0(1,0,0,0, 0, (k % 3) == 2, 1);
    // H=9, P=6: always high, tick every 6.
    add(1'b1, 3'b000, 1'b1, 2'd0, 16'd6, 16'd9, 3'b000, 3'b000, 3'b000);
    for (int k = 0; k < 8; k++) a0(1,0,0,0, 1, (k % 6) == 5, 1);
    // P=1 behaves as P=2.
    add(1'b1, 3'b000, 1'b1, 2'd0, 16'd1, 16'd1, 3'b000, 3'b000, 3'b000);
    for (int k = 0; k < 6; k++) a0(1,0,0,0, (k % 2) == 0, (k % 2) == 1, 1);
    // Isolation: channel 1 gets P=4,H=1; an out-of-range write to ch 3 is dropped.
    add(1'b1, 3'b000, 1'b1, 2'd1, 16'd4, 16'd1, 3'b000, 3'b000, 3'b000);
    add(1'b0, 3'b000, 1'b1, 2'd3, 16'd2, 16'd1, 3'b000, 3'b000, 3'b000);
    for (int k = 0; k < 8; k++)
      add(1'b0, 3'b011, 1'b0, 2'd0, 16'd0, 16'd0,
          {1'b0, (k % 4) == 0, 1'b1}, {1'b0, (k % 4) == 3, 1'b0}, 3'b011);

    do_reset(-1);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset(i);
      step(vecs[i].en, vecs[i].we, vecs[i].ch, vecs[i].per, vecs[i].high,
           vecs[i].car, vecs[i].tick, vecs[i].bsy, i);
    end

    // Defaults: 439 high, 877 low, tick on the 1316th cycle.
    do_reset(1000);
    for (int k = 0; k < 2 * 1316 + 3; k++)
      step(3'b001, 1'b0, 2'd0, 16'd0, 16'd0,
           {2'b00, (k % 1316) < 439}, {2'b00, (k % 1316) == 1315}, 3'b001, 2000 + k);
    // Pending write, then a reset while high: the shadow must revert to defaults.
    step(3'b001, 1'b1, 2'd0, 16'd4, 16'd1, 3'b001, 3'b000, 3'b001, 5000);
    do_reset(5001);
    for (int k = 0; k < 10; k++)
      step(3'b001, 1'b0, 2'd0, 16'd0, 16'd0, 3'b001, 3'b000, 3'b001, 6000 + k);

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got %0d leftover want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
